// File: rtl/ifu_fetch_queue.sv
// ----------------------------------------------------------------------------
// ifu_fetch_queue
//
// Fetch controller in front of the ICache. It owns the fetch PC and presents
// it to the cache every cycle. On a hit, it captures {pc, inst} into a small
// FIFO and hands the head entry to the IDU over a valid/ready handshake.
// A redirect from EXU (branch/jump/trap, optionally with fence.i) flushes the
// FIFO and reloads the PC.
//
// Parameters
//   RESET_PC : PC value loaded on reset
//   QDEPTH   : FIFO entries (power of two, >= 2)
//
// Ports
//   clock           in   clock
//   reset           in   synchronous, active-high reset
//   redirect_valid  in   reload PC and flush FIFO this cycle
//   redirect_pc     in   new PC (bits [1:0] are forced to 00)
//   fencei_req      in   fence.i retiring (only meaningful with redirect_valid)
//   icache_addr     out  fetch address (the PC register)
//   icache_hit      in   cache hit for icache_addr, same cycle
//   icache_inst     in   instruction word for icache_addr, same cycle
//   icache_fencei   out  one-cycle cache invalidate pulse
//   out_valid       out  FIFO head valid
//   out_ready       in   IDU accepts head
//   out_pc          out  PC of head entry
//   out_inst        out  instruction of head entry
//   stall_cnt       out  miss-stall cycle counter (only with IFU_STALL_CNT_EN)
//
// Optional feature: define IFU_STALL_CNT_EN to add the stall_cnt port. It
// counts (wrapping) every cycle where fetch is blocked purely by a cache miss.
// ----------------------------------------------------------------------------
module ifu_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        fencei_req,
    output logic [31:0] icache_addr,
    input  logic        icache_hit,
    input  logic [31:0] icache_inst,
    output logic        icache_fencei,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
`ifdef IFU_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int             AW         = $clog2(QDEPTH);
    localparam logic [AW:0]    QDEPTH_CNT = (AW + 1)'(QDEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   wr_ptr_reg, wr_ptr_next;
    logic [31:0]   pc_reg, pc_next;
    logic [AW:0]   count;
    logic          full;
    logic          deq;
    logic          enq;

    logic [31:0]   entry_pc   [QDEPTH];
    logic [31:0]   entry_inst [QDEPTH];

    assign count     = wr_ptr_reg - rd_ptr_reg;
    assign full      = (count == QDEPTH_CNT);
    assign out_valid = (count != '0);
    assign deq       = out_valid & out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign enq       = icache_hit & ~redirect_valid & (~full | deq);

    assign icache_addr   = pc_reg;
    assign icache_fencei = redirect_valid & fencei_req & ~reset;

    // Storage: one register pair per entry. The head is read combinationally
    // so an entry written at edge N is visible during cycle N+1.
    generate
        for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
            logic [31:0] entry_pc_reg;
            logic [31:0] entry_inst_reg;
            logic        entry_we;

            assign entry_we = enq & (wr_ptr_reg[AW-1:0] == AW'(gi));

            always_ff @(posedge clock) begin
                if (entry_we) begin
                    entry_pc_reg   <= pc_reg;
                    entry_inst_reg <= icache_inst;
                end
            end

            assign entry_pc[gi]   = entry_pc_reg;
            assign entry_inst[gi] = entry_inst_reg;
        end
    endgenerate

    assign out_pc   = entry_pc[rd_ptr_reg[AW-1:0]];
    assign out_inst = entry_inst[rd_ptr_reg[AW-1:0]];

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        pc_next     = pc_reg;
        if (redirect_valid) begin
            // Redirect wins over everything: flush, drop the handshake, reload.
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            pc_next     = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (deq) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            if (enq) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
                pc_next     = pc_reg + 32'd4;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            pc_reg     <= RESET_PC;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            pc_reg     <= pc_next;
        end
    end

`ifdef IFU_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    // Only miss-induced stalls count; back-pressure (full) and redirects don't.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else if (~icache_hit & ~redirect_valid & ~full) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_ifu_fetch_queue.sv
module tb_ifu_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h3000_0000;
    localparam int          QDEPTH   = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fencei_req;
    logic [31:0] icache_addr;
    logic        icache_hit;
    logic [31:0] icache_inst;
    logic        icache_fencei;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
`ifdef IFU_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clock = ~clock;

    ifu_fetch_queue #(
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fencei_req     (fencei_req),
        .icache_addr    (icache_addr),
        .icache_hit     (icache_hit),
        .icache_inst    (icache_inst),
        .icache_fencei  (icache_fencei),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
`ifdef IFU_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    int compared_cnt   = 0;
    int mismatched_cnt = 0;

    // Reference model: the fetch PC plus a queue of pending {pc, inst}.
    bit          model_known = 1'b0;
    logic [31:0] m_pc;
    logic [31:0] q_pc   [$];
    logic [31:0] q_inst [$];
    logic [31:0] m_stall;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        compared_cnt++;
        if (act !== exp) begin
            mismatched_cnt++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check outputs against the model, then
    // advance the model by the same rules the controller must obey.
    task automatic drive_cycle(input bit rst, input bit rv, input logic [31:0] rpc,
                               input bit fr, input bit hit, input logic [31:0] inst,
                               input bit rdy);
        bit do_deq, do_enq, is_full;
        @(negedge clock);
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        fencei_req     = fr;
        icache_hit     = hit;
        icache_inst    = inst;
        out_ready      = rdy;
        #1;
        check_value("fencei", {31'd0, icache_fencei}, {31'd0, rv & fr & ~rst});
        if (model_known) begin
            check_value("addr", icache_addr, m_pc);
            check_value("valid", {31'd0, out_valid}, {31'd0, q_pc.size() != 0});
            if (q_pc.size() != 0) begin
                check_value("head_pc", out_pc, q_pc[0]);
                check_value("head_inst", out_inst, q_inst[0]);
            end
`ifdef IFU_STALL_CNT_EN
            check_value("stall_cnt", stall_cnt, m_stall);
`endif
        end
        @(posedge clock);
        if (rst) begin
            m_pc = RESET_PC;
            q_pc.delete();
            q_inst.delete();
            m_stall = 32'd0;
            model_known = 1'b1;
        end else if (model_known) begin
            if (rv) begin
                q_pc.delete();
                q_inst.delete();
                m_pc = rpc & 32'hFFFF_FFFC;
            end else begin
                is_full = (q_pc.size() == QDEPTH);
                do_deq  = (q_pc.size() != 0) && rdy;
                do_enq  = hit && (!is_full || do_deq);
                if (!hit && !is_full) m_stall = m_stall + 32'd1;
                if (do_deq) begin
                    $display("deq pc=%08h inst=%08h", q_pc[0], q_inst[0]);
                    void'(q_pc.pop_front());
                    void'(q_inst.pop_front());
                end
                if (do_enq) begin
                    q_pc.push_back(m_pc);
                    q_inst.push_back(inst);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] stall_before;
        logic [31:0] rpc;
        int          r;

        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; fencei_req = 1'b0;
        icache_hit = 1'b0; icache_inst = '0; out_ready = 1'b0;

        // 1. reset, then sustained hits with ready
        drive_cycle(1, 0, 0, 0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0, 0);
        #1;
        check_value("rst_addr", icache_addr, 32'h3000_0000);
        check_value("rst_valid", {31'd0, out_valid}, 32'd0);
        drive_cycle(0, 0, 0, 0, 1, 32'h1111_0000, 1);
        #1;
        check_value("t1_first_pc", out_pc, 32'h3000_0000);
        for (int i = 1; i < 6; i++) drive_cycle(0, 0, 0, 0, 1, 32'h1111_0000 + i, 1);

        // 2. back-pressure: exactly QDEPTH entries accepted
        drive_cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive_cycle(0, 0, 0, 0, 1, 32'h2222_0000 + i, 0);
        #1;
        check_value("t2_pc_stop", icache_addr, RESET_PC + 4 * QDEPTH);
        check_value("t2_head", out_pc, 32'h3000_0000);
        // drain (misses), then steady hits with one entry in flight
        drive_cycle(0, 0, 0, 0, 0, 0, 1);
        drive_cycle(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 0, 1, 32'h2233_0000 + i, 1);

        // 3. five miss cycles mid-stream
        stall_before = m_stall;
        for (int i = 0; i < 5; i++) drive_cycle(0, 0, 0, 0, 0, 0, 1);
        #1;
        check_value("t3_drained", {31'd0, out_valid}, 32'd0);
`ifdef IFU_STALL_CNT_EN
        check_value("t3_stall5", stall_cnt, stall_before + 32'd5);
`endif

        // 4. redirect while full
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 0, 1, 32'h4444_0000 + i, 0);
        #1;
        check_value("t4_full_valid", {31'd0, out_valid}, 32'd1);
        drive_cycle(0, 1, 32'h3000_0102, 0, 1, 32'h4444_00FF, 0);
        #1;
        check_value("t4_valid_off", {31'd0, out_valid}, 32'd0);
        check_value("t4_addr", icache_addr, 32'h3000_0100);
        drive_cycle(0, 0, 0, 0, 1, 32'h4444_0100, 0);
        #1;
        check_value("t4_new_pc", out_pc, 32'h3000_0100);

        // 5. fence.i with and without redirect
        drive_cycle(0, 1, 32'h3000_0200, 1, 1, 32'h5555_0000, 1);
        #1;
        check_value("t5_no_enq", {31'd0, out_valid}, 32'd0);
        drive_cycle(0, 0, 0, 1, 1, 32'h5555_0001, 0);
        drive_cycle(0, 0, 0, 1, 1, 32'h5555_0002, 0);
        #1;
        check_value("t5_no_flush", {31'd0, out_valid}, 32'd1);

        // 6. PC wrap, then reset mid-stream
        drive_cycle(0, 1, 32'hFFFF_FFFF, 0, 0, 0, 1);
        drive_cycle(0, 0, 0, 0, 1, 32'h6666_0000, 1);
        #1;
        check_value("t6_wrap_addr", icache_addr, 32'h0000_0000);
        check_value("t6_wrap_pc", out_pc, 32'hFFFF_FFFC);
        drive_cycle(0, 0, 0, 0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 1, 32'h6666_0001, 0);
        #1;
        check_value("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        check_value("t6_rst_addr", icache_addr, RESET_PC);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            drive_cycle(r < 1, (r >= 1) && (r < 7), rpc, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatched_cnt);
        $finish;
    end

endmodule
